booth_r4_mult_seq: RTL and testbench

//  Iterative radix-4 Booth multiplier for the MIPS execute stage (MULT/MULTU -> HI/LO).

---
 rtl/booth_pkg.sv | 8 +
 rtl/booth_r4_recode.sv | 19 +
 rtl/booth_r4_mult_seq.sv | 70 +++++++
 tb/tb_booth_r4_mult_seq.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// booth_pkg: shared types and helpers for the radix-4 Booth sequential multiplier
package booth_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} digit_e;
  function automatic int iter_count(input int width);
    return width / 2 + 1;
  endfunction
endpackage

// File: rtl/booth_r4_recode.sv
// booth_r4_recode: maps a 3-bit multiplier window to Booth partial-product controls
module booth_r4_recode
  import booth_pkg::*;
(
  input  logic [2:0] grp,
  output logic       neg,
  output logic       two,
  output logic       zero
);
  digit_e digit;
  always_comb
    digit = (grp == 3'b000 || grp == 3'b111) ? ZERO :
            (grp == 3'b011) ? POS2 :
            (grp == 3'b100) ? NEG2 :
            grp[2] ? NEG1 : POS1;
  assign neg  = digit == NEG1 || digit == NEG2;
  assign two  = digit == POS2 || digit == NEG2;
  assign zero = digit == ZERO;
endmodule

// File: rtl/booth_r4_mult_seq.sv
// booth_r4_mult_seq: iterative radix-4 Booth multiplier, signed/unsigned, valid/ready on both sides
module booth_r4_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic               abort,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);
  localparam int ITER = iter_count(WIDTH);
  localparam int CW   = $clog2(ITER + 1);
  state_e           state, state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH+1:0] mcand;
  logic [WIDTH+2:0] acc, mult, m3, mag, pp, sum;
  logic             neg, two, zero, accept, last;
  booth_r4_recode u_recode (
    .grp  (mult[2:0]),
    .neg  (neg),
    .two  (two),
    .zero (zero)
  );
  assign accept    = in_valid && state == IDLE && !abort;
  assign last      = cnt == CW'(ITER - 1);
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  // product bits enter mult from the top; after ITER shifts the LSB sits at mult[1]
  assign product   = {acc[WIDTH-3:0], mult[WIDTH+2:1]};
  always_comb begin
    state_n = state;
    if (abort && state != IDLE) state_n = IDLE;
    else if (accept) state_n = CALC;
    else if (state == CALC && last) state_n = DONE;
    else if (state == DONE && out_ready) state_n = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    m3  = {mcand[WIDTH+1], mcand};
    mag = zero ? '0 : two ? {m3[WIDTH+1:0], 1'b0} : m3;
    pp  = neg ? -mag : mag;
    sum = acc + pp;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mcand <= '0;
      acc   <= '0;
      mult  <= '0;
      cnt   <= '0;
    end else if (accept) begin
      mcand <= {{2{is_signed & op_a[WIDTH-1]}}, op_a};
      mult  <= {{2{is_signed & op_b[WIDTH-1]}}, op_b, 1'b0};
      acc   <= '0;
      cnt   <= '0;
    end else if (state == CALC && !abort) begin
      acc   <= {{2{sum[WIDTH+2]}}, sum[WIDTH+2:2]};
      mult  <= {sum[1:0], mult[WIDTH+2:2]};
      cnt   <= cnt + CW'(1);
    end
endmodule

// File: tb/tb_booth_r4_mult_seq.sv
// tb_booth_r4_mult_seq: directed and random checks of the Booth multiplier at WIDTH=8 and WIDTH=32
module tb_booth_r4_mult_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv8, ir8, s8, ab8, ov8, or8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        iv32, ir32, s32, ab32, ov32, or32;
  logic [31:0] a32, b32;
  logic [63:0] p32;
  logic [63:0] q8[$], q32[$];
  int          n_run = 0, n_fail = 0;

  always #5 clk = ~clk;

  booth_r4_mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .is_signed(s8),
    .op_a(a8), .op_b(b8), .abort(ab8), .out_valid(ov8), .out_ready(or8), .product(p8)
  );
  booth_r4_mult_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .is_signed(s32),
    .op_a(a32), .op_b(b32), .abort(ab32), .out_valid(ov32), .out_ready(or32), .product(p32)
  );

  function automatic logic [63:0] model(input logic s, input logic [63:0] a, input logic [63:0] b,
                                        input int w);
    logic [63:0] m, ea, eb;
    m  = (64'd1 << w) - 64'd1;
    ea = (s && a[w-1]) ? (a | ~m) : (a & m);
    eb = (s && b[w-1]) ? (b | ~m) : (b & m);
    return (ea * eb) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue8(input logic s, input logic [7:0] a, input logic [7:0] b);
    check("in_ready8", 64'(ir8), 64'd1);
    iv8 = 1'b1; s8 = s; a8 = a; b8 = b;
    q8.push_back(model(s, 64'(a), 64'(b), 8));
    @(negedge clk);
    iv8 = 1'b0;
  endtask

  task automatic wait8(input int lat);
    int cyc;
    cyc = 0;
    while (!ov8 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("latency8", 64'(cyc), 64'(lat));
  endtask

  task automatic take8(input string tag);
    logic [63:0] e;
    e = q8.size() != 0 ? q8.pop_front() : 'x;
    check(tag, 64'(p8), e);
    or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
    check("ov_drop8", 64'(ov8), 64'd0);
    check("ir_rise8", 64'(ir8), 64'd1);
  endtask

  initial begin
    logic [63:0] e;
    int cyc;
    rst_n = 1'b0;
    {iv8, s8, ab8, or8, a8, b8} = '0;
    {iv32, s32, ab32, or32, a32, b32} = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(ir8), 64'd1);
    check("rst_out_valid", 64'(ov8), 64'd0);
    check("rst_product", 64'(p8), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue8(1'b1, 8'hFF, 8'h01);
    wait8(5);
    check("s_ff_01_const", 64'(p8), 64'hFFFF);
    take8("s_ff_01");
    issue8(1'b0, 8'hFF, 8'hFF);
    wait8(5);
    check("u_ff_ff_const", 64'(p8), 64'hFE01);
    take8("u_ff_ff");
    issue8(1'b1, 8'h80, 8'h80);
    wait8(5);
    check("s_min_min_const", 64'(p8), 64'h4000);
    take8("s_min_min");
    issue8(1'b1, 8'h7F, 8'h80);
    wait8(5);
    check("s_7f_80_const", 64'(p8), 64'hC080);
    take8("s_7f_80");
    issue8(1'b0, 8'h00, 8'h5A);
    wait8(5);
    take8("zero_operand");

    // back-pressure: product and handshake flags must hold
    issue8(1'b1, 8'h85, 8'h33);
    wait8(5);
    e = q8[0];
    for (int i = 0; i < 10; i++) begin
      check("bp_product", 64'(p8), e);
      check("bp_out_valid", 64'(ov8), 64'd1);
      check("bp_in_ready", 64'(ir8), 64'd0);
      @(negedge clk);
    end
    take8("bp_accept");

    // abort mid-calculation while the next op is already waiting
    issue8(1'b0, 8'd7, 8'd9);
    repeat (2) @(negedge clk);
    ab8 = 1'b1; iv8 = 1'b1; s8 = 1'b0; a8 = 8'd3; b8 = 8'd5;
    @(negedge clk);
    ab8 = 1'b0;
    check("abort_idle_ready", 64'(ir8), 64'd1);
    check("abort_no_valid", 64'(ov8), 64'd0);
    void'(q8.pop_back());
    q8.push_back(model(1'b0, 64'd3, 64'd5, 8));
    @(negedge clk);
    iv8 = 1'b0;
    wait8(5);
    check("after_abort_const", 64'(p8), 64'd15);
    take8("after_abort");

    // abort in IDLE beats in_valid
    ab8 = 1'b1; iv8 = 1'b1; a8 = 8'd2; b8 = 8'd2;
    repeat (3) begin
      @(negedge clk);
      check("abort_idle_no_accept", 64'(ir8), 64'd1);
    end
    ab8 = 1'b0; iv8 = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_idle_no_out", 64'(ov8), 64'd0);

    // abort together with out_ready in DONE
    issue8(1'b1, 8'hF0, 8'h0F);
    wait8(5);
    ab8 = 1'b1; or8 = 1'b1;
    @(negedge clk);
    ab8 = 1'b0; or8 = 1'b0;
    void'(q8.pop_front());
    check("abort_done_valid", 64'(ov8), 64'd0);
    check("abort_done_ready", 64'(ir8), 64'd1);

    // asynchronous reset between clock edges
    issue8(1'b1, 8'h12, 8'h34);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ready", 64'(ir8), 64'd1);
    check("async_rst_valid", 64'(ov8), 64'd0);
    check("async_rst_product", 64'(p8), 64'd0);
    q8.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue8(1'b1, 8'hFA, 8'h07);
    wait8(5);
    check("after_rst_const", 64'(p8), 64'hFFD6);
    take8("after_rst");

    // WIDTH=32: corners followed by random pairs
    for (int i = 0; i < 2000; i++) begin
      s32 = 1'(i == 0) | (i > 1 && $urandom_range(0, 1) == 1);
      a32 = (i < 2) ? (i == 0 ? 32'h8000_0000 : 32'hFFFF_FFFF) : $urandom;
      b32 = (i < 2) ? (i == 0 ? 32'h8000_0000 : 32'hFFFF_FFFF) : $urandom;
      if (i == 0) check("w32_min_min_model", model(1'b1, 64'h8000_0000, 64'h8000_0000, 32),
                        64'h4000_0000_0000_0000);
      check("in_ready32", 64'(ir32), 64'd1);
      iv32 = 1'b1;
      q32.push_back(model(s32, 64'(a32), 64'(b32), 32));
      @(negedge clk);
      iv32 = 1'b0;
      cyc = 0;
      while (!ov32 && cyc < 60) begin
        @(negedge clk);
        cyc++;
      end
      check("latency32", 64'(cyc), 64'd17);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      e = q32.size() != 0 ? q32.pop_front() : 'x;
      if (i == 1) check("w32_umax_const", p32, 64'hFFFF_FFFE_0000_0001);
      check("w32_product", p32, e);
      or32 = 1'b1;
      @(negedge clk);
      or32 = 1'b0;
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
